fcache_word_port: RTL and testbench

Word-access initiator for `fcache`. Accepts single 16-bit word read/write requests from a client, turns each into 256-bit line transactions on the `fcache` read/write/addr/wData/rData interface, and returns the extracted word. Writes are performed as read-modify-write of the full line. Sits between the datapath and `fcache`, and owns every `fcache` control signal.

---
 rtl/fcache_pkg.sv | 18 +
 rtl/fcache_word_merge.sv | 25 ++
 rtl/fcache_word_port.sv | 112 +++++++++++
 tb/tb_fcache_word_port.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcache_pkg.sv
// Shared types and constants for fcache and its initiators.
// Line/word geometry and the word-port FSM state encoding.
package fcache_pkg;

  localparam int LINE_W         = 256;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = 16;
  localparam int WIDX_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    RESP
  } state_t;

endpackage

// File: rtl/fcache_word_merge.sv
// Combinational word extract / word replace on a 256-bit fcache line.
// Word i lives in line[16i+15:16i].
module fcache_word_merge
  import fcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WIDX_W-1:0] widx,
  input  logic [WORD_W-1:0] new_word,
  output logic [WORD_W-1:0] old_word,
  output logic [LINE_W-1:0] merged_line
);

  // Constant slices per word keep the mux free of variable-width indexing.
  always_comb begin
    old_word    = '0;
    merged_line = line;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (widx == WIDX_W'(i)) begin
        old_word                          = line[i*WORD_W +: WORD_W];
        merged_line[i*WORD_W +: WORD_W]   = new_word;
      end
    end
  end

endmodule

// File: rtl/fcache_word_port.sv
// Single-word read / read-modify-write initiator in front of fcache.
// Owns all fcache control; one request in flight at a time.
//
// state | meaning
// IDLE  | ready for a client request
// RD    | read strobe to fcache for the captured line
// WAIT  | down-count the remaining read latency, capture rData at terminal count
// WR    | write strobe with the merged line
// RESP  | one-cycle completion pulse with the old word
module fcache_word_port
  import fcache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W+3:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [WORD_W-1:0]   rsp_rdata,
  output logic                read,
  output logic                write,
  output logic [ADDR_W-1:0]   addr,
  output logic [LINE_W-1:0]   wData,
  input  logic [LINE_W-1:0]   rData
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t              state_q;
  state_t              state_d;
  logic                we_q;
  logic [WIDX_W-1:0]   widx_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [1:0]          cnt_q;
  logic [WORD_W-1:0]   old_word_q;
  logic [WORD_W-1:0]   ext_word;
  logic [LINE_W-1:0]   merged_line;
  logic                accept;
  logic                cnt_tc;
  logic                capture;

  assign accept  = req_valid && req_ready;
  assign cnt_tc  = (cnt_q == 2'd0);
  assign capture = (state_q == WAIT) && cnt_tc;

  fcache_word_merge u_merge (
    .line        (rData),
    .widx        (widx_q),
    .new_word    (wdata_q),
    .old_word    (ext_word),
    .merged_line (merged_line)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RD;
      RD:      state_d = WAIT;
      WAIT:    if (cnt_tc) state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !reset;
    read      = (state_q == RD);
    write     = (state_q == WR);
    rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      widx_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      old_word_q <= '0;
      addr       <= '0;
      wData      <= '0;
      rsp_rdata  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        widx_q  <= req_addr[WIDX_W-1:0];
        wdata_q <= req_wdata;
        addr    <= req_addr[ADDR_W+3:4];
      end
      if (state_q == RD)             cnt_q <= LAT_INIT;
      else if (state_q == WAIT && !cnt_tc) cnt_q <= cnt_q - 2'd1;
      if (capture) begin
        old_word_q <= ext_word;
        if (we_q) wData     <= merged_line;
        else      rsp_rdata <= ext_word;
      end
      // Writes publish the old word only on entry to RESP so it holds until then.
      if (state_q == WR) rsp_rdata <= old_word_q;
    end
  end

endmodule

// File: tb/tb_fcache_word_port.sv
// Bench for fcache_word_port: two instances (RD_LAT 1 and 3) against an
// fcache line-memory responder and a word-level reference memory.
module tb_fcache_word_port;
  import fcache_pkg::*;

  localparam int AW   = 16;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst       [2];
  logic             req_valid [2];
  logic             req_ready [2];
  logic             req_we    [2];
  logic [AW+3:0]    req_addr  [2];
  logic [15:0]      req_wdata [2];
  logic             rsp_valid [2];
  logic [15:0]      rsp_rdata [2];
  logic             rd        [2];
  logic             wr        [2];
  logic [AW-1:0]    addr      [2];
  logic [255:0]     wdata     [2];
  logic [255:0]     rdata     [2];

  int vectors = 0;
  int miscompares = 0;
  int both_hi = 0;
  int rem [2] = '{-1, -1};
  logic [AW-1:0] pend_a [2];

  logic [255:0] mem  [int];
  logic [15:0]  refw [int];

  fcache_word_port #(.ADDR_W(AW), .RD_LAT(LAT0)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .read(rd[0]), .write(wr[0]),
    .addr(addr[0]), .wData(wdata[0]), .rData(rdata[0])
  );

  fcache_word_port #(.ADDR_W(AW), .RD_LAT(LAT1)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .read(rd[1]), .write(wr[1]),
    .addr(addr[1]), .wData(wdata[1]), .rData(rdata[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int lkey(input int k, input logic [AW-1:0] la);
    return k * 65536 + int'(la);
  endfunction

  function automatic int wkey(input int k, input logic [AW+3:0] wa);
    return k * 1048576 + int'(wa);
  endfunction

  function automatic logic [255:0] mline(input int key);
    if (mem.exists(key)) return mem[key];
    return '0;
  endfunction

  function automatic logic [15:0] rword(input int k, input logic [AW+3:0] wa);
    if (refw.exists(wkey(k, wa))) return refw[wkey(k, wa)];
    return 16'h0000;
  endfunction

  // fcache responder: rData is valid only for the edge RD_LAT cycles after read.
  always @(posedge clk) begin : fcache_model
    logic          s_rd [2];
    logic          s_wr [2];
    logic [AW-1:0] s_a  [2];
    logic [255:0]  s_wd [2];
    for (int k = 0; k < 2; k++) begin
      s_rd[k] = rd[k];
      s_wr[k] = wr[k];
      s_a[k]  = addr[k];
      s_wd[k] = wdata[k];
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (s_rd[k] && s_wr[k]) both_hi++;
      if (s_wr[k]) mem[lkey(k, s_a[k])] = s_wd[k];
      if (s_rd[k]) begin
        rem[k]    = lat_of(k) - 1;
        pend_a[k] = s_a[k];
      end else if (rem[k] >= 0) begin
        rem[k]--;
      end
      if (rem[k] == 0) rdata[k] = mline(lkey(k, pend_a[k]));
      else             rdata[k] = {8{$urandom}};
    end
  end

  task automatic run_req(input int k, input logic we, input logic [AW+3:0] a,
                         input logic [15:0] wd, output int rd_c, output int wr_c,
                         output int rsp_c, output logic [15:0] rsp_d,
                         output logic [AW-1:0] rd_a, output logic rdy_low,
                         output time t_acc);
    int n;
    rd_c = -1; wr_c = -1; rsp_c = -1; rsp_d = '0; rd_a = '0; rdy_low = 1'b1;
    t_acc = 0; n = 0;
    @(negedge clk);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = wd;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    for (int c = 1; c <= 16 && rsp_c < 0; c++) begin
      @(negedge clk);
      req_valid[k] = 1'b0;
      if (rd[k]) begin
        rd_c = (rd_c < 0) ? c : -2;
        rd_a = addr[k];
      end
      if (wr[k]) wr_c = (wr_c < 0) ? c : -2;
      if (rsp_valid[k]) begin
        rsp_c = c;
        rsp_d = rsp_rdata[k];
      end
      if (req_ready[k]) rdy_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b1; req_we[k] = 1'b1;
      req_addr[k] = 20'h12345; req_wdata[k] = 16'h5A5A;
    end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({rd[k], wr[k], rsp_valid[k], req_ready[k]} !== 4'b0000) begin
          miscompares++;
          $display("FAIL reset_ctrl inst%0d: rd/wr/rsp/rdy=%b%b%b%b want 0000",
                   k, rd[k], wr[k], rsp_valid[k], req_ready[k]);
        end
        vectors++;
        if (addr[k] !== '0 || wdata[k] !== '0 || rsp_rdata[k] !== '0) begin
          miscompares++;
          $display("FAIL reset_data inst%0d: addr=%h rsp_rdata=%h wData_nz=%0d want zeros",
                   k, addr[k], rsp_rdata[k], wdata[k] != '0);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (req_ready[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_release_ready inst%0d: got %b want 1", k, req_ready[k]);
      end
    end
  endtask

  task automatic test_write_read(input int k);
    int rd_c, wr_c, rsp_c; logic [15:0] d; logic [AW-1:0] ra; logic rl; time t;
    run_req(k, 1'b1, 20'h00013, 16'hBEEF, rd_c, wr_c, rsp_c, d, ra, rl, t);
    vectors++;
    if (d !== 16'h0000 || wr_c !== 2 + lat_of(k)) begin
      miscompares++;
      $display("FAIL wr_word inst%0d: old=%h wr_cyc=%0d want 0000/%0d", k, d, wr_c, 2 + lat_of(k));
    end
    refw[wkey(k, 20'h00013)] = 16'hBEEF;
    run_req(k, 1'b0, 20'h00013, 16'h0000, rd_c, wr_c, rsp_c, d, ra, rl, t);
    vectors++;
    if (d !== 16'hBEEF || wr_c !== -1) begin
      miscompares++;
      $display("FAIL rd_word inst%0d: got %h wr_cyc=%0d want beef/-1", k, d, wr_c);
    end
    run_req(k, 1'b0, 20'h00012, 16'h0000, rd_c, wr_c, rsp_c, d, ra, rl, t);
    vectors++;
    if (d !== 16'h0000) begin
      miscompares++;
      $display("FAIL rd_neighbour inst%0d: got %h want 0000", k, d);
    end
  endtask

  task automatic test_merge(input int k);
    int rd_c, wr_c, rsp_c; logic [15:0] d; logic [AW-1:0] ra; logic rl; time t;
    logic [255:0] exp_line;
    mem[lkey(k, 16'h0002)] = {256{1'b1}};
    for (int w = 0; w < 16; w++) refw[wkey(k, {16'h0002, 4'(w)})] = 16'hFFFF;
    run_req(k, 1'b1, 20'h0002F, 16'h0000, rd_c, wr_c, rsp_c, d, ra, rl, t);
    refw[wkey(k, 20'h0002F)] = 16'h0000;
    vectors++;
    if (d !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL merge_old inst%0d: got %h want ffff", k, d);
    end
    @(negedge clk);
    exp_line = {16'h0000, {15{16'hFFFF}}};
    vectors++;
    if (mline(lkey(k, 16'h0002)) !== exp_line) begin
      miscompares++;
      $display("FAIL merge_line inst%0d: got %h want %h", k, mline(lkey(k, 16'h0002)), exp_line);
    end
  endtask

  task automatic test_top_addr(input int k);
    int rd_c, wr_c, rsp_c; logic [15:0] d, v; logic [AW-1:0] ra; logic rl; time t;
    v = 16'($urandom);
    run_req(k, 1'b1, 20'hFFFFF, v, rd_c, wr_c, rsp_c, d, ra, rl, t);
    refw[wkey(k, 20'hFFFFF)] = v;
    vectors++;
    if (ra !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL top_addr inst%0d: addr=%h want ffff", k, ra);
    end
    run_req(k, 1'b0, 20'hFFFFF, 16'h0000, rd_c, wr_c, rsp_c, d, ra, rl, t);
    vectors++;
    if (d !== v) begin
      miscompares++;
      $display("FAIL top_readback inst%0d: got %h want %h", k, d, v);
    end
  endtask

  task automatic test_reset_mid_write(input int k);
    int rd_c, wr_c, rsp_c, n; logic [15:0] d; logic [AW-1:0] ra; logic rl; time t;
    logic wr_seen, rsp_seen;
    run_req(k, 1'b1, 20'h00075, 16'h1234, rd_c, wr_c, rsp_c, d, ra, rl, t);
    refw[wkey(k, 20'h00075)] = 16'h1234;
    @(negedge clk);
    req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = 20'h00075; req_wdata[k] = 16'hAAAA;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    @(negedge clk);
    rst[k] = 1'b1;
    @(negedge clk);
    rst[k] = 1'b0;
    vectors++;
    if (addr[k] !== '0 || rsp_rdata[k] !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs inst%0d: addr=%h rsp_rdata=%h want 0/0", k, addr[k], rsp_rdata[k]);
    end
    wr_seen = wr[k]; rsp_seen = rsp_valid[k];
    repeat (10) begin
      @(negedge clk);
      wr_seen  |= wr[k];
      rsp_seen |= rsp_valid[k];
    end
    vectors++;
    if (wr_seen !== 1'b0 || rsp_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_dropped inst%0d: write=%b rsp_valid=%b want 0/0", k, wr_seen, rsp_seen);
    end
    run_req(k, 1'b0, 20'h00075, 16'h0000, rd_c, wr_c, rsp_c, d, ra, rl, t);
    vectors++;
    if (d !== 16'h1234) begin
      miscompares++;
      $display("FAIL midrst_line inst%0d: got %h want 1234", k, d);
    end
  endtask

  task automatic test_back_to_back(input int k);
    int rd_c, wr_c, rsp_c; logic [15:0] d, v; logic [AW-1:0] ra; logic rl;
    time t1, t2; logic [AW+3:0] a; int L;
    L = lat_of(k);
    run_req(k, 1'b0, 20'h00100, 16'h0000, rd_c, wr_c, rsp_c, d, ra, rl, t1);
    run_req(k, 1'b0, 20'h00101, 16'h0000, rd_c, wr_c, rsp_c, d, ra, rl, t2);
    vectors++;
    if (t2 - t1 !== time'((3 + L) * 10)) begin
      miscompares++;
      $display("FAIL b2b_read inst%0d: spacing=%0t want %0d", k, t2 - t1, (3 + L) * 10);
    end
    a = 20'h00104; v = 16'($urandom);
    run_req(k, 1'b1, a, v, rd_c, wr_c, rsp_c, d, ra, rl, t1);
    refw[wkey(k, a)] = v;
    a = 20'h00105; v = 16'($urandom);
    run_req(k, 1'b1, a, v, rd_c, wr_c, rsp_c, d, ra, rl, t2);
    refw[wkey(k, a)] = v;
    vectors++;
    if (t2 - t1 !== time'((4 + L) * 10)) begin
      miscompares++;
      $display("FAIL b2b_write inst%0d: spacing=%0t want %0d", k, t2 - t1, (4 + L) * 10);
    end
  endtask

  task automatic test_random(input int k, input int count);
    int rd_c, wr_c, rsp_c, L, exp_wr, exp_rsp; logic [15:0] d, v, exp_old;
    logic [AW-1:0] ra; logic rl; time t; logic we; logic [AW+3:0] a;
    logic [AW-1:0] pool [4];
    pool = '{16'h0001, 16'h0002, 16'h0035, 16'hFFFF};
    L = lat_of(k);
    for (int i = 0; i < count; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = {pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
      v  = 16'($urandom);
      exp_old = rword(k, a);
      exp_wr  = we ? 2 + L : -1;
      exp_rsp = we ? 3 + L : 2 + L;
      run_req(k, we, a, v, rd_c, wr_c, rsp_c, d, ra, rl, t);
      if (we) refw[wkey(k, a)] = v;
      vectors++;
      if (rd_c !== 1 || wr_c !== exp_wr || rsp_c !== exp_rsp) begin
        miscompares++;
        $display("FAIL rand_timing inst%0d #%0d: rd/wr/rsp=%0d/%0d/%0d want 1/%0d/%0d",
                 k, i, rd_c, wr_c, rsp_c, exp_wr, exp_rsp);
      end
      vectors++;
      if (rl !== 1'b1 || ra !== a[AW+3:4]) begin
        miscompares++;
        $display("FAIL rand_ready_addr inst%0d #%0d: ready_low=%b addr=%h want 1/%h",
                 k, i, rl, ra, a[AW+3:4]);
      end
      vectors++;
      if (d !== exp_old) begin
        miscompares++;
        $display("FAIL rand_data inst%0d #%0d addr=%h: got %h want %h", k, i, a, d, exp_old);
      end
    end
  endtask

  task automatic test_consistency();
    int k; logic [AW+3:0] wa; logic [255:0] line; logic [15:0] w;
    @(negedge clk);
    foreach (refw[key]) begin
      k    = key / 1048576;
      wa   = 20'(key % 1048576);
      line = mline(lkey(k, wa[AW+3:4]));
      w    = line[int'(wa[3:0]) * 16 +: 16];
      vectors++;
      if (w !== refw[key]) begin
        miscompares++;
        $display("FAIL line_content inst%0d addr=%h: got %h want %h", k, wa, w, refw[key]);
      end
    end
    vectors++;
    if (both_hi !== 0) begin
      miscompares++;
      $display("FAIL read_write_overlap: got %0d cycles want 0", both_hi);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench timed out");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0;
    end
    test_reset();
    for (int k = 0; k < 2; k++) begin
      test_write_read(k);
      test_merge(k);
      test_top_addr(k);
      test_reset_mid_write(k);
      test_back_to_back(k);
      test_random(k, 40);
    end
    test_consistency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
